// File: rtl/program_store_if.sv
// ---------------------------------------------------------------------------
// program_store_if
//
// Bundles the load port and the instruction bus of the program store.
//
//   load_mode           upstream -> store   1 = load a program, 0 = run it
//   load_data[7:0]      upstream -> store   program byte to store
//   load_valid          upstream -> store   a byte is on load_data
//   load_ready          store -> upstream   a byte can be accepted this cycle
//   instruction_address core -> store       PC of the core
//   instruction[7:0]    store -> core       registered instruction byte
//   hold_cpu            store -> core       active-high reset for the core
//   program_length[8:0] store -> upstream   committed program bytes, 0..256
//   full                store -> upstream   current load has 256 bytes
//
// master: the side that drives mode/data/address (loader + core).
// slave:  the program store itself.
// ---------------------------------------------------------------------------
interface program_store_if;
   logic       load_mode;
   logic [7:0] load_data;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] instruction_address;
   logic [7:0] instruction;
   logic       hold_cpu;
   logic [8:0] program_length;
   logic       full;

   modport master (
      output load_mode, load_data, load_valid, instruction_address,
      input  load_ready, instruction, hold_cpu, program_length, full
   );

   modport slave (
      input  load_mode, load_data, load_valid, instruction_address,
      output load_ready, instruction, hold_cpu, program_length, full
   );
endinterface

// File: rtl/program_store.sv
// ---------------------------------------------------------------------------
// program_store
//
// 256 x 8 program memory with a valid/ready byte loader, serving the stored
// program to the 8-bit core. While loading, or with no program present, the
// core is held in reset and sees the self-jump opcode 8'hFF.
//
// Ports:
//   oscillator  board clock, all state updates on its rising edge
//   reset       asynchronous, active-low reset
//   bus         program_store_if.slave (load port + instruction bus)
// ---------------------------------------------------------------------------
module program_store (
   input logic            oscillator,
   input logic            reset,
   program_store_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [7:0] HALT_OPCODE = 8'hFF;  // jump -1: the PC holds

   state_t     state_q, state_d;
   logic [8:0] count_q, count_d;
   logic [8:0] length_q, length_d;
   logic       accept;
   logic       hold_q;
   logic [7:0] instr_q;
   logic [7:0] mem [0:255];

   assign bus.load_ready     = (state_q == LOAD) && (count_q < 9'd256);
   assign bus.full           = (count_q == 9'd256);
   assign bus.program_length = length_q;
   assign bus.hold_cpu       = hold_q;
   assign bus.instruction    = instr_q;

   // Next-state logic. Leaving LOAD has priority over the handshake, so a
   // byte offered in the cycle load_mode falls is not taken.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d  = state_q;
      count_d  = count_q;
      length_d = length_q;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load_mode) begin
               state_d  = LOAD;
               count_d  = 9'd0;
               length_d = 9'd0;
            end else if (length_q != 9'd0) begin
               state_d = RUN;
            end
         end
         LOAD: begin
            if (!bus.load_mode) begin
               length_d = count_q;
               state_d  = (count_q != 9'd0) ? RUN : IDLE;
            end else if (bus.load_valid && bus.load_ready) begin
               accept  = 1'b1;
               count_d = count_q + 9'd1;
            end
         end
         RUN: begin
            if (bus.load_mode) begin
               state_d  = LOAD;
               count_d  = 9'd0;
               length_d = 9'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge oscillator or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= 9'd0;
         length_q <= 9'd0;
         hold_q   <= 1'b1;
         instr_q  <= HALT_OPCODE;
      end else begin
         // NOTE: non-blocking assignments, so every register here samples
         // the pre-edge values regardless of statement order.
         state_q  <= state_d;
         count_q  <= count_d;
         length_q <= length_d;
         // Registered from the next state so the core's async reset input
         // sees a clean edge aligned with the state change.
         hold_q   <= (state_d != RUN);
         // 9-bit compare: a 256-byte program makes every address valid.
         if ((state_q == RUN) && ({1'b0, bus.instruction_address} < length_q))
            instr_q <= mem[bus.instruction_address];
         else
            instr_q <= HALT_OPCODE;
      end
   end

   // NOTE: the array has no reset; reads are gated by program_length, so
   // stale contents never reach the core.
   always_ff @(posedge oscillator) begin
      if (accept)
         mem[count_q[7:0]] <= bus.load_data;
   end

endmodule

// File: tb/tb_program_store.sv
// ---------------------------------------------------------------------------
// tb_program_store
//
// Self-checking bench for program_store. Reads go through a scoreboard queue:
// the expected byte is pushed when the address is driven and popped when the
// registered instruction appears one cycle later. Expected read data comes
// from a small bench-side model of memory contents and committed length.
// ---------------------------------------------------------------------------
module tb_program_store;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   logic osc;
   logic reset;

   program_store_if bus ();

   program_store dut (
      .oscillator (osc),
      .reset      (reset),
      .bus        (bus.slave)
   );

   initial osc = 1'b0;
   always #5 osc = ~osc;

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [7:0] exp_q [$];
   logic [7:0] model_mem [0:255];
   int         model_len = 0;
   rd_vec_t    run_vecs [5];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge osc);
      #1;
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] a);
      return (int'(a) < model_len) ? model_mem[a] : 8'hFF;
   endfunction

   task automatic read_expect(input logic [7:0] a, input logic [7:0] e);
      bus.instruction_address = a;
      exp_q.push_back(e);
      tick();
      if (exp_q.size() == 0)
         check("scoreboard_empty", 32'd0, 32'd1);
      else
         check($sformatf("read[%0d]", a), bus.instruction, exp_q.pop_front());
   endtask

   task automatic read_model(input logic [7:0] a);
      read_expect(a, model_read(a));
   endtask

   initial begin
      run_vecs[0] = '{addr: 8'd0,   exp: 8'h1B};
      run_vecs[1] = '{addr: 8'd1,   exp: 8'h44};
      run_vecs[2] = '{addr: 8'd2,   exp: 8'hC3};
      run_vecs[3] = '{addr: 8'd3,   exp: 8'hFF};
      run_vecs[4] = '{addr: 8'd255, exp: 8'hFF};

      bus.load_mode           = 1'b0;
      bus.load_data           = 8'h00;
      bus.load_valid          = 1'b0;
      bus.instruction_address = 8'h00;
      reset                   = 1'b0;

      // ---- reset state ----
      repeat (3) tick();
      check("rst_instruction", bus.instruction, 8'hFF);
      check("rst_hold_cpu", bus.hold_cpu, 1'b1);
      check("rst_load_ready", bus.load_ready, 1'b0);
      check("rst_program_length", bus.program_length, 9'd0);
      check("rst_full", bus.full, 1'b0);
      reset = 1'b1;
      tick();
      check("idle_hold_cpu", bus.hold_cpu, 1'b1);

      // ---- load 3 bytes and run ----
      bus.load_mode = 1'b1;
      tick();
      check("load_entry_ready", bus.load_ready, 1'b1);
      check("load_entry_hold", bus.hold_cpu, 1'b1);
      bus.load_valid = 1'b1;
      bus.load_data = 8'h1B; tick();
      bus.load_data = 8'h44; tick();
      bus.load_data = 8'hC3; tick();
      // Byte offered while load_mode falls must not be accepted.
      bus.load_data = 8'h77;
      bus.load_mode = 1'b0;
      tick();
      bus.load_valid = 1'b0;
      model_mem[0] = 8'h1B; model_mem[1] = 8'h44; model_mem[2] = 8'hC3;
      model_len = 3;
      check("run_program_length", bus.program_length, 9'd3);
      check("run_hold_cpu", bus.hold_cpu, 1'b0);
      check("run_load_ready", bus.load_ready, 1'b0);
      for (int i = 0; i < 5; i++)
         read_expect(run_vecs[i].addr, run_vecs[i].exp);

      // ---- bytes offered in RUN are dropped ----
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h55;
      repeat (2) tick();
      bus.load_valid = 1'b0;
      check("run_drop_length", bus.program_length, 9'd3);
      check("run_drop_ready", bus.load_ready, 1'b0);
      read_model(8'd0);

      // ---- reload from RUN ----
      bus.instruction_address = 8'd0;
      bus.load_mode = 1'b1;
      tick();
      model_len = 0;
      check("reload_hold_cpu", bus.hold_cpu, 1'b1);
      check("reload_program_length", bus.program_length, 9'd0);
      tick();
      check("reload_instruction", bus.instruction, 8'hFF);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h0C;
      tick();
      bus.load_valid = 1'b0;
      bus.load_mode  = 1'b0;
      tick();
      model_mem[0] = 8'h0C;
      model_len = 1;
      check("reload_length", bus.program_length, 9'd1);
      check("reload_run_hold", bus.hold_cpu, 1'b0);
      read_model(8'd0);
      read_model(8'd1);   // stale 0x44 still in memory, must be gated

      // ---- full capacity ----
      bus.load_mode = 1'b1;
      tick();
      model_len = 0;
      bus.load_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.load_data = 8'(i);
         model_mem[i] = 8'(i);
         tick();
         if (i == 254)
            check("full_before_last", bus.full, 1'b0);
      end
      check("full_flag", bus.full, 1'b1);
      check("full_ready", bus.load_ready, 1'b0);
      bus.load_data = 8'hAA;
      tick();
      check("full_drop_flag", bus.full, 1'b1);
      bus.load_valid = 1'b0;
      bus.load_mode  = 1'b0;
      tick();
      model_len = 256;
      check("full_program_length", bus.program_length, 9'd256);
      check("full_hold_cpu", bus.hold_cpu, 1'b0);
      read_model(8'd255);
      read_model(8'd0);
      read_model(8'd128);

      // ---- reset mid-load ----
      bus.load_mode = 1'b1;
      tick();
      model_len = 0;
      check("full_cleared_on_load", bus.full, 1'b0);
      bus.load_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.load_data = 8'(8'hE0 + i);
         tick();
      end
      bus.load_valid = 1'b0;
      bus.load_mode  = 1'b0;
      reset = 1'b0;
      #2;
      check("midrst_program_length", bus.program_length, 9'd0);
      check("midrst_instruction", bus.instruction, 8'hFF);
      check("midrst_hold_cpu", bus.hold_cpu, 1'b1);
      check("midrst_ready", bus.load_ready, 1'b0);
      reset = 1'b1;
      repeat (3) tick();
      check("midrst_idle_hold", bus.hold_cpu, 1'b1);
      read_model(8'd0);

      // ---- bytes offered in IDLE are dropped ----
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h55;
      repeat (2) tick();
      bus.load_valid = 1'b0;
      check("idle_drop_ready", bus.load_ready, 1'b0);
      check("idle_drop_length", bus.program_length, 9'd0);
      check("idle_drop_full", bus.full, 1'b0);
      check("idle_drop_hold", bus.hold_cpu, 1'b1);
      read_model(8'd0);

      if (exp_q.size() != 0)
         check("scoreboard_leftover", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/program_store.md
# program_store

Program memory and loader sitting directly upstream of the 8-bit microprocessor core. It captures a program byte-by-byte through a valid/ready load port, then serves it as the core's `instruction` bus, addressed by the core's `instruction_address`. While a program is being loaded or none is present, it holds the core in reset and returns a self-jump (halt) opcode.

## Interface
- No parameters. Memory depth is fixed at 256 x 8, the full 8-bit PC range.
- `oscillator`  in  1  Board clock. All state is updated on its rising edge; this is the undivided clock.
- `reset`  in  1  Asynchronous, active-low reset.
- `load_mode`  in  1  Mode switch: 1 = load a program, 0 = run it.
- `load_data`  in  8  Program byte to store.
- `load_valid`  in  1  Upstream has a byte on `load_data`; single-cycle or held.
- `load_ready`  out  1  Block can accept a byte this cycle.
- `instruction_address`  in  8  PC from the core.
- `instruction`  out  8  Registered instruction byte to the core.
- `hold_cpu`  out  1  Drives the core's active-high reset; 1 whenever not in RUN.
- `program_length`  out  9  Number of committed program bytes, 0..256.
- `full`  out  1  Load count has reached 256.

## Operation
- Storage: 256 x 8 array, not cleared by reset. Reads are gated by `program_length`, so stale contents are never visible.
- Internal registers:
  - 9-bit `count`: bytes accepted in the current load.
  - 9-bit `program_length`.
  - 2-bit state.
- States and transitions:
  - IDLE (reset state): `load_mode`=1 -> LOAD with `count`<=0 and `program_length`<=0. `load_mode`=0 and `program_length`!=0 -> RUN. Otherwise stay in IDLE.
  - LOAD:
    - Handshake: a byte is accepted when `load_valid && load_ready`, which writes `mem[count[7:0]]`<=`load_data` and sets `count`<=`count`+1.
    - On `load_mode`=0, `program_length`<=`count`. The next state is RUN if `count`!=0, else IDLE.
    - A byte offered in the same cycle `load_mode` falls is NOT accepted.
  - RUN: `load_mode`=1 -> LOAD, clearing `count` and `program_length`.
- `load_ready` = (state==LOAD) && (`count`<256). It is combinational from registered state.
- `full` = (`count`==256). It stays set until the next LOAD entry or reset.
- A byte offered while `load_ready`=0 is dropped silently; `count` and memory are unchanged.
- Instruction output, registered every cycle:
  - In RUN: `instruction`<=(`{1'b0,instruction_address}` < `program_length`) ? `mem[instruction_address]` : 8'hFF.
  - Outside RUN: `instruction`<=8'hFF.
  - 8'hFF decodes as jump with immediate -1, i.e. PC holds, so the core halts safely.
- `hold_cpu` = (state!=RUN). It is registered, so it is glitch-free toward the core's asynchronous reset.
- Width rule: the address comparison is done at 9 bits. A program of length 256 therefore makes every address valid.

## Timing
- Reset values (asserted `reset`=0):
  - state IDLE, `count`=0, `program_length`=0.
  - `instruction`=8'hFF, `hold_cpu`=1, `load_ready`=0, `full`=0.
- Read latency: 1 `oscillator` cycle from `instruction_address` to `instruction`. The core's divided clock is at least 2.5e7 cycles per edge, so the bus is stable long before the core samples it.
- Load throughput: 1 byte per cycle while `load_valid` is held and `load_ready`=1.
- LOAD -> RUN: 1 cycle after `load_mode` falls. `hold_cpu` deasserts on that same edge, and the core restarts at PC 0.
- RUN -> LOAD: 1 cycle after `load_mode` rises. On that edge `hold_cpu`=1 and `program_length`=0, and on the following edge `instruction`=8'hFF.
- Reset mid-load: the partial program is discarded (`program_length`=0). The memory array is untouched but unreadable.

## Test plan
- Reset check: hold `reset`=0 -> `instruction`=FF, `hold_cpu`=1, `load_ready`=0, `program_length`=0, `full`=0.
- Load and run:
  - Stimulus: `load_mode`=1, push 0x1B, 0x44, 0xC3 on consecutive cycles, then `load_mode`=0.
  - Required: `program_length`=3 and `hold_cpu`=0 one cycle later. Addresses 0, 1, 2 read 1B, 44, C3 one cycle after each is presented; address 3 and address 255 read FF.
- Dropped bytes: assert `load_valid` with 0x55 while in IDLE and while in RUN -> `count` and `program_length` unchanged; a later read of address 0 is unaffected.
- Full capacity:
  - Stimulus: load 256 bytes (value = index), then offer a 257th byte 0xAA.
  - Required: `full`=1 and `load_ready`=0 after the 256th byte; 0xAA is dropped; `program_length`=256; address 255 reads 0xFF and address 0 reads 0x00.
- Reset mid-load: after 5 accepted bytes, pulse `reset`=0 -> state IDLE, `program_length`=0, `instruction`=FF. With `load_mode`=0 the block stays in IDLE with `hold_cpu`=1.
- Reload from RUN: while running a 3-byte program, raise `load_mode` -> `hold_cpu`=1 next cycle, `instruction`=FF, `program_length`=0. Then load 1 byte 0x0C and drop `load_mode` -> `program_length`=1; address 0 reads 0C and address 1 reads FF.
